// File: rtl/cache_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_arb_pkg : shared types and constants for cache_bus_arbiter     |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } arb_owner_t;

    localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
    localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/cache_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_bus_arbiter : shares one SRAM-like master between I$ and D$    |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module cache_bus_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              clrn,

    input  logic              i_req,
    input  logic              i_wr,
    input  logic [1:0]        i_size,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_addr_ok,
    output logic              i_data_ok,

    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,

    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,

    output logic              proto_err
);

    localparam logic [2:0] c_LIMIT = 3'(STARVE_LIMIT);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    arb_owner_t r_owner;
    arb_owner_t w_owner_nxt;
    logic [2:0] r_starve_cnt;
    logic [2:0] w_starve_nxt;
    logic       r_proto_err;
    logic       w_proto_err_nxt;

    logic       w_arb;
    logic       w_any_req;
    logic       w_pick_inst;
    logic       w_addr_ok;
    logic       w_data_ok;
    logic       w_busy;
    logic       w_own_inst;

    assign w_any_req   = i_req | d_req;
    // Instruction wins only when alone or once data has starved it long enough.
    assign w_pick_inst = i_req & (~d_req | (r_starve_cnt == c_LIMIT));

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_starve_nxt    = i_req ? r_starve_cnt : 3'd0;
        w_proto_err_nxt = r_proto_err;
        w_arb           = 1'b0;
        w_addr_ok       = 1'b0;
        w_data_ok       = 1'b0;

        case (r_state)
            IDLE: begin
                w_arb = 1'b1;
                if (m_data_ok) begin
                    w_proto_err_nxt = 1'b1;
                end
            end
            ADDR: begin
                w_addr_ok = m_addr_ok;
                if (m_addr_ok) begin
                    if (m_data_ok) begin
                        w_data_ok = 1'b1;
                        w_arb     = 1'b1;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end else if (m_data_ok) begin
                    w_proto_err_nxt = 1'b1;
                end
            end
            DATA: begin
                w_data_ok = m_data_ok;
                if (m_data_ok) begin
                    w_arb = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Shared by IDLE and completion cycles, so back-to-back grants skip IDLE.
        if (w_arb) begin
            if (w_any_req) begin
                w_state_nxt = ADDR;
                if (w_pick_inst) begin
                    w_owner_nxt  = OWN_INST;
                    w_starve_nxt = 3'd0;
                end else begin
                    w_owner_nxt = OWN_DATA;
                    if (i_req) begin
                        w_starve_nxt = (r_starve_cnt == c_LIMIT) ? c_LIMIT
                                                                 : r_starve_cnt + 3'd1;
                    end
                end
            end else begin
                w_state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state      <= IDLE;
            r_owner      <= OWN_DATA;
            r_starve_cnt <= 3'd0;
            r_proto_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_proto_err  <= w_proto_err_nxt;
        end
    end

    assign w_busy     = (r_state != IDLE);
    assign w_own_inst = (r_owner == OWN_INST);

    assign m_req   = (r_state == ADDR);
    assign m_wr    = w_busy & (w_own_inst ? i_wr : d_wr);
    assign m_size  = w_busy ? (w_own_inst ? i_size  : d_size)  : 2'd0;
    assign m_addr  = w_busy ? (w_own_inst ? i_addr  : d_addr)  : '0;
    assign m_wdata = w_busy ? (w_own_inst ? i_wdata : d_wdata) : '0;

    assign i_rdata = w_busy ? m_rdata : '0;
    assign d_rdata = w_busy ? m_rdata : '0;

    assign i_addr_ok = w_addr_ok &  w_own_inst;
    assign d_addr_ok = w_addr_ok & ~w_own_inst;
    assign i_data_ok = w_data_ok &  w_own_inst;
    assign d_data_ok = w_data_ok & ~w_own_inst;

    assign proto_err = r_proto_err;

endmodule
`default_nettype wire
